nmea_rmc_time_parser: RTL



---
 rtl/nmea_rmc_time_parser_if.sv | 21 ++
 rtl/nmea_rmc_time_parser.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/nmea_rmc_time_parser_if.sv
// Receiver byte stream in, decoded UTC time out, for nmea_rmc_time_parser.
interface nmea_rmc_time_parser_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] hour_bcd;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic       fix_ok;
   logic       time_valid;
   logic       sentence_err;

   modport master (
      output rx_data, rx_valid,
      input  hour_bcd, min_bcd, sec_bcd, fix_ok, time_valid, sentence_err
   );

   modport slave (
      input  rx_data, rx_valid,
      output hour_bcd, min_bcd, sec_bcd, fix_ok, time_valid, sentence_err
   );
endinterface

// File: rtl/nmea_rmc_time_parser.sv
// NMEA "$xxRMC" parser: publishes UTC hhmmss as packed BCD plus the A/V fix flag.
// Define NMEA_CHECKSUM_EN to require and verify the "*hh" checksum before commit.
module nmea_rmc_time_parser #(
   parameter int MAX_LEN = 82
) (
   input logic                   clk,
   input logic                   reset,
   nmea_rmc_time_parser_if.slave bus
);
   localparam logic [7:0] LEN_LIM   = 8'(MAX_LEN);
   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_COMMA  = 8'h2C;
   localparam logic [7:0] CH_CR     = 8'h0D;
   localparam logic [7:0] CH_LF     = 8'h0A;
   localparam logic [7:0] CH_A      = 8'h41;
`ifdef NMEA_CHECKSUM_EN
   localparam logic [7:0] CH_STAR   = 8'h2A;
`endif

   typedef enum logic [3:0] {
      S_IDLE, S_TALKER, S_TYPE, S_TIME, S_FRAC, S_STATUS,
      S_STAT_COMMA, S_SKIP, S_CKSUM, S_COMMIT
   } state_t;

   state_t      state;
   logic        rx_valid_d;
   logic [2:0]  cnt;
   logic [7:0]  len;
   logic [23:0] stage;
   logic        fix_stage;
`ifdef NMEA_CHECKSUM_EN
   logic [7:0]  ck_acc;
   logic [3:0]  ck_hi;
`endif

   logic accept;
   logic past_type;
   logic term;
   logic time_in_range;

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= 8'h30) && (c <= 8'h39);
   endfunction

   function automatic logic [7:0] type_char(input logic [2:0] idx);
      case (idx)
         3'd0:    return 8'h52;
         3'd1:    return 8'h4D;
         3'd2:    return 8'h43;
         default: return CH_COMMA;
      endcase
   endfunction

   function automatic logic two_digit_le(input logic [3:0] tens, input logic [3:0] ones,
                                         input logic [6:0] lim);
      logic [6:0] v;
      v = 7'(tens) * 7'd10 + 7'(ones);
      return v <= lim;
   endfunction

`ifdef NMEA_CHECKSUM_EN
   function automatic logic is_hex(input logic [7:0] c);
      return is_digit(c) || ((c >= 8'h41) && (c <= 8'h46));
   endfunction

   function automatic logic [3:0] hex_val(input logic [7:0] c);
      return is_digit(c) ? c[3:0] : (c[3:0] + 4'd9);
   endfunction
`endif

   // A level-style new_data flag is turned into exactly one accept per byte.
   assign accept        = bus.rx_valid && !rx_valid_d;
   assign past_type     = state inside {S_TIME, S_FRAC, S_STATUS, S_STAT_COMMA, S_SKIP, S_CKSUM};
   assign term          = (bus.rx_data == CH_CR) || (bus.rx_data == CH_LF);
   assign time_in_range = two_digit_le(stage[23:20], stage[19:16], 7'd23) &&
                          two_digit_le(stage[15:12], stage[11:8],  7'd59) &&
                          two_digit_le(stage[7:4],   stage[3:0],   7'd59);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= S_IDLE;
         rx_valid_d       <= 1'b0;
         cnt              <= '0;
         len              <= '0;
         stage            <= '0;
         fix_stage        <= 1'b0;
         bus.hour_bcd     <= 8'h00;
         bus.min_bcd      <= 8'h00;
         bus.sec_bcd      <= 8'h00;
         bus.fix_ok       <= 1'b0;
         bus.time_valid   <= 1'b0;
         bus.sentence_err <= 1'b0;
`ifdef NMEA_CHECKSUM_EN
         ck_acc           <= '0;
         ck_hi            <= '0;
`endif
      end else begin
         rx_valid_d       <= bus.rx_valid;
         bus.time_valid   <= 1'b0;
         bus.sentence_err <= 1'b0;
         if (state == S_IDLE) len <= '0;

         // Range check happens here so all four outputs load together or not at all.
         if (state == S_COMMIT) begin
            if (time_in_range) begin
               bus.hour_bcd   <= stage[23:16];
               bus.min_bcd    <= stage[15:8];
               bus.sec_bcd    <= stage[7:0];
               bus.fix_ok     <= fix_stage;
               bus.time_valid <= 1'b1;
            end else begin
               bus.sentence_err <= 1'b1;
            end
            state <= S_IDLE;
         end else if (accept) begin
            if (bus.rx_data == CH_DOLLAR) begin
               bus.sentence_err <= past_type;
               state            <= S_TALKER;
               cnt              <= '0;
               len              <= 8'd1;
`ifdef NMEA_CHECKSUM_EN
               ck_acc           <= '0;
`endif
            end else if (past_type && (len >= LEN_LIM)) begin
               bus.sentence_err <= 1'b1;
               state            <= S_IDLE;
            end else if (state != S_IDLE) begin
               len <= len + 8'd1;
`ifdef NMEA_CHECKSUM_EN
               if ((state != S_CKSUM) && (bus.rx_data != CH_STAR))
                  ck_acc <= ck_acc ^ bus.rx_data;
`endif
               case (state)
                  S_TALKER: begin
                     if (cnt == 3'd1) begin
                        state <= S_TYPE;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + 3'd1;
                     end
                  end
                  // Other sentence types are dropped without an error pulse.
                  S_TYPE: begin
                     if (bus.rx_data != type_char(cnt)) begin
                        state <= S_IDLE;
                     end else if (cnt == 3'd3) begin
                        state <= S_TIME;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + 3'd1;
                     end
                  end
                  S_TIME: begin
                     if (is_digit(bus.rx_data)) begin
                        stage <= {stage[19:0], bus.rx_data[3:0]};
                        if (cnt == 3'd5) begin
                           state <= S_FRAC;
                           cnt   <= '0;
                        end else begin
                           cnt <= cnt + 3'd1;
                        end
                     end else begin
                        bus.sentence_err <= 1'b1;
                        state            <= S_IDLE;
                     end
                  end
                  S_FRAC: begin
                     if (bus.rx_data == CH_COMMA) state <= S_STATUS;
                  end
                  S_STATUS: begin
                     fix_stage <= (bus.rx_data == CH_A);
                     state     <= S_STAT_COMMA;
                  end
                  S_STAT_COMMA: begin
                     if (bus.rx_data == CH_COMMA) begin
                        state <= S_SKIP;
                     end else begin
                        bus.sentence_err <= 1'b1;
                        state            <= S_IDLE;
                     end
                  end
                  S_SKIP: begin
`ifdef NMEA_CHECKSUM_EN
                     if (bus.rx_data == CH_STAR) begin
                        state <= S_CKSUM;
                        cnt   <= '0;
                     end else if (term) begin
                        bus.sentence_err <= 1'b1;
                        state            <= S_IDLE;
                     end
`else
                     if (term) state <= S_COMMIT;
`endif
                  end
`ifdef NMEA_CHECKSUM_EN
                  // cnt walks: high nibble, low nibble, then the CR/LF terminator.
                  S_CKSUM: begin
                     if (cnt == 3'd0) begin
                        if (is_hex(bus.rx_data)) begin
                           ck_hi <= hex_val(bus.rx_data);
                           cnt   <= 3'd1;
                        end else begin
                           bus.sentence_err <= 1'b1;
                           state            <= S_IDLE;
                        end
                     end else if (cnt == 3'd1) begin
                        if (is_hex(bus.rx_data) && ({ck_hi, hex_val(bus.rx_data)} == ck_acc)) begin
                           cnt <= 3'd2;
                        end else begin
                           bus.sentence_err <= 1'b1;
                           state            <= S_IDLE;
                        end
                     end else begin
                        if (term) begin
                           state <= S_COMMIT;
                        end else begin
                           bus.sentence_err <= 1'b1;
                           state            <= S_IDLE;
                        end
                     end
                  end
`endif
                  default: state <= S_IDLE;
               endcase
            end
         end
      end
   end
endmodule
